// File: rtl/conv_layer_sched.sv
// Layer-level sequencer for the conv engine: per output channel, fetch the
// 3x3 signed weight set from a synchronous weight memory into the kernel
// registers, run the engine for one image pass, then move to the next channel.
module conv_layer_sched #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CH_LEN    = 2,
    parameter int unsigned WADDR_LEN = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  layer_done,
    output logic [CH_LEN-1:0]     ch,
    output logic                  w_en,
    output logic [WADDR_LEN-1:0]  w_addr,
    input  logic signed [7:0]     w_data,
    output logic signed [7:0]     kernel0,
    output logic signed [7:0]     kernel1,
    output logic signed [7:0]     kernel2,
    output logic signed [7:0]     kernel3,
    output logic signed [7:0]     kernel4,
    output logic signed [7:0]     kernel5,
    output logic signed [7:0]     kernel6,
    output logic signed [7:0]     kernel7,
    output logic signed [7:0]     kernel8,
    output logic                  conv,
    input  logic                  conv_done
);

    localparam int unsigned K_LEN   = 4;
    localparam int unsigned N_TAPS  = 9;
    localparam logic [CH_LEN-1:0] LAST_CH = CH_LEN'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPT,
        S_RUN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [K_LEN-1:0]       k_q, k_d;
    logic [CH_LEN-1:0]      ch_q, ch_d;
    logic                   busy_q, busy_d;
    logic                   layer_done_q, layer_done_d;
    logic                   w_en_q, w_en_d;
    logic [WADDR_LEN-1:0]   w_addr_q, w_addr_d;
    logic                   conv_q, conv_d;
    logic signed [7:0]      kern_q [N_TAPS];
    logic signed [7:0]      kern_d [N_TAPS];

    // Next-state, weight capture and next-cycle output values.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        ch_d    = ch_q;
        kern_d  = kern_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_FETCH;
                    ch_d    = '0;
                    k_d     = '0;
                end
            end
            S_FETCH: begin
                // Data for address base+k-1 arrives while k is on the bus.
                for (int i = 0; i < N_TAPS - 1; i++) begin
                    if (k_q == K_LEN'(i + 1)) begin
                        kern_d[i] = w_data;
                    end
                end
                if (k_q == K_LEN'(N_TAPS - 1)) begin
                    state_d = S_CAPT;
                end else begin
                    k_d = k_q + K_LEN'(1);
                end
            end
            S_CAPT: begin
                kern_d[N_TAPS-1] = w_data;
                state_d          = S_RUN;
            end
            S_RUN: begin
                if (conv_done) begin
                    if (ch_q == LAST_CH) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        ch_d    = ch_q + CH_LEN'(1);
                        k_d     = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cancel wins over everything; registers keep what they already hold.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            k_d     = k_q;
            ch_d    = ch_q;
            kern_d  = kern_q;
        end

        busy_d       = (state_d != S_IDLE);
        layer_done_d = (state_d == S_DONE);
        conv_d       = (state_d == S_RUN);
        w_en_d       = (state_d == S_FETCH);
        w_addr_d     = w_addr_q;
        if (w_en_d) begin
            w_addr_d = WADDR_LEN'(ch_d) * WADDR_LEN'(N_TAPS) + WADDR_LEN'(k_d);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            ch_q         <= '0;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b0;
            w_en_q       <= 1'b0;
            w_addr_q     <= '0;
            conv_q       <= 1'b0;
            for (int i = 0; i < N_TAPS; i++) begin
                kern_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            ch_q         <= ch_d;
            busy_q       <= busy_d;
            layer_done_q <= layer_done_d;
            w_en_q       <= w_en_d;
            w_addr_q     <= w_addr_d;
            conv_q       <= conv_d;
            for (int i = 0; i < N_TAPS; i++) begin
                kern_q[i] <= kern_d[i];
            end
        end
    end

    assign busy       = busy_q;
    assign layer_done = layer_done_q;
    assign ch         = ch_q;
    assign w_en       = w_en_q;
    assign w_addr     = w_addr_q;
    assign conv       = conv_q;
    assign kernel0    = kern_q[0];
    assign kernel1    = kern_q[1];
    assign kernel2    = kern_q[2];
    assign kernel3    = kern_q[3];
    assign kernel4    = kern_q[4];
    assign kernel5    = kern_q[5];
    assign kernel6    = kern_q[6];
    assign kernel7    = kern_q[7];
    assign kernel8    = kern_q[8];

endmodule

// File: tb/tb_conv_layer_sched.sv
// Bench for conv_layer_sched: a 4-channel instance driven through full layers,
// abort, reset and ignored-input cases, plus a 1-channel instance for the
// degenerate layer. Expectations come from a cycle timeline and weight tables.
module tb_conv_layer_sched;

    localparam int NCH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start, abort, conv_done;
    logic              busy, layer_done, w_en, conv;
    logic [1:0]        ch;
    logic [5:0]        w_addr;
    logic signed [7:0] w_data;
    logic signed [7:0] kern0, kern1, kern2, kern3, kern4, kern5, kern6, kern7, kern8;
    logic [71:0]       kcat;
    logic [7:0]        wmem [64];

    logic              start1, abort1, conv_done1;
    logic              busy1, layer_done1, w_en1, conv1;
    logic [0:0]        ch1;
    logic [3:0]        w_addr1;
    logic signed [7:0] w_data1;
    logic signed [7:0] m0, m1, m2, m3, m4, m5, m6, m7, m8;
    logic [71:0]       kcat1;
    logic [7:0]        wmem1 [16];

    int n_chk  = 0;
    int n_pass = 0;

    conv_layer_sched #(.NUM_CH(4), .CH_LEN(2), .WADDR_LEN(6)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .layer_done(layer_done), .ch(ch),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .kernel0(kern0), .kernel1(kern1), .kernel2(kern2),
        .kernel3(kern3), .kernel4(kern4), .kernel5(kern5),
        .kernel6(kern6), .kernel7(kern7), .kernel8(kern8),
        .conv(conv), .conv_done(conv_done)
    );

    conv_layer_sched #(.NUM_CH(1), .CH_LEN(1), .WADDR_LEN(4)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .busy(busy1), .layer_done(layer_done1), .ch(ch1),
        .w_en(w_en1), .w_addr(w_addr1), .w_data(w_data1),
        .kernel0(m0), .kernel1(m1), .kernel2(m2),
        .kernel3(m3), .kernel4(m4), .kernel5(m5),
        .kernel6(m6), .kernel7(m7), .kernel8(m8),
        .conv(conv1), .conv_done(conv_done1)
    );

    assign kcat  = {kern8, kern7, kern6, kern5, kern4, kern3, kern2, kern1, kern0};
    assign kcat1 = {m8, m7, m6, m5, m4, m3, m2, m1, m0};

    // Synchronous weight memories: one-cycle read latency.
    always @(posedge clk) begin
        if (w_en) w_data <= wmem[w_addr];
        if (w_en1) w_data1 <= wmem1[w_addr1];
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] exp_kern(input int c);
        logic [71:0] r;
        for (int j = 0; j < 9; j++) r[j*8 +: 8] = wmem[c*9 + j];
        return r;
    endfunction

    // mode 0: full layer; 1: abort on ch1 together with conv_done; 2: reset mid-RUN on ch1.
    task automatic run_layer(input int mode, input int base_lat, input bit rnd);
        int lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < 9; k++) begin
                check("fetch_wen", 72'(w_en), 72'(1));
                check("fetch_addr", 72'(w_addr), 72'(c*9 + k));
                check("fetch_ch", 72'(ch), 72'(c));
                check("fetch_conv", 72'(conv), 72'(0));
                check("fetch_busy", 72'(busy), 72'(1));
                if (rnd) begin
                    start     = 1'($urandom_range(0, 1));
                    conv_done = 1'($urandom_range(0, 1));
                end
                tick();
                start     = 1'b0;
                conv_done = 1'b0;
            end
            check("capt_wen", 72'(w_en), 72'(0));
            check("capt_conv", 72'(conv), 72'(0));
            tick();
            lat = rnd ? int'($urandom_range(0, 25)) : base_lat;
            for (int r = 0; r <= lat; r++) begin
                check("run_conv", 72'(conv), 72'(1));
                check("run_busy", 72'(busy), 72'(1));
                check("run_ldone", 72'(layer_done), 72'(0));
                if (r == 0 || r == lat) check("run_kern", kcat, exp_kern(c));
                if (mode == 2 && c == 1 && r == 0) begin
                    #3;
                    rst = 1'b0;
                    #1;
                    check("rst_conv", 72'(conv), 72'(0));
                    check("rst_busy", 72'(busy), 72'(0));
                    check("rst_kern", kcat, 72'(0));
                    check("rst_ch", 72'(ch), 72'(0));
                    check("rst_waddr", 72'(w_addr), 72'(0));
                    tick();
                    rst = 1'b1;
                    tick();
                    check("rst_idle", 72'(busy), 72'(0));
                    return;
                end
                if (r == lat) conv_done = 1'b1;
                if (r == lat && c == 1 && mode == 1) abort = 1'b1;
                if (rnd) start = 1'($urandom_range(0, 1));
                tick();
                conv_done = 1'b0;
                start     = 1'b0;
                abort     = 1'b0;
            end
            if (mode == 1 && c == 1) begin
                check("abort_conv", 72'(conv), 72'(0));
                check("abort_busy", 72'(busy), 72'(0));
                check("abort_ch", 72'(ch), 72'(1));
                check("abort_kern", kcat, exp_kern(1));
                for (int i = 0; i < 5; i++) begin
                    check("abort_ldone", 72'(layer_done), 72'(0));
                    check("abort_wen", 72'(w_en), 72'(0));
                    tick();
                end
                return;
            end
        end
        check("done_pulse", 72'(layer_done), 72'(1));
        check("done_busy", 72'(busy), 72'(1));
        check("done_conv", 72'(conv), 72'(0));
        tick();
        check("post_busy", 72'(busy), 72'(0));
        check("post_ldone", 72'(layer_done), 72'(0));
        check("post_ch", 72'(ch), 72'(NCH - 1));
        check("post_kern", kcat, exp_kern(NCH - 1));
    endtask

    initial begin
        logic [71:0] exp1;
        rst = 1'b0; start = 1'b0; abort = 1'b0; conv_done = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; conv_done1 = 1'b0;
        for (int i = 0; i < 64; i++) wmem[i] = 8'(((i / 9) * 16) + (i % 9));
        for (int i = 0; i < 16; i++) wmem1[i] = 8'h00;
        wmem1[0] = 8'h80; wmem1[1] = 8'hFF; wmem1[2] = 8'h7F;
        wmem1[3] = 8'h01; wmem1[4] = 8'h00; wmem1[5] = 8'hFE;
        wmem1[6] = 8'h81; wmem1[7] = 8'h55; wmem1[8] = 8'hAA;

        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 72'(busy), 72'(0));
        check("reset_conv", 72'(conv), 72'(0));
        check("reset_wen", 72'(w_en), 72'(0));
        check("reset_waddr", 72'(w_addr), 72'(0));
        check("reset_ch", 72'(ch), 72'(0));
        check("reset_ldone", 72'(layer_done), 72'(0));
        check("reset_kern", kcat, 72'(0));
        rst = 1'b1;
        tick();

        // Reference layer: weight ch*16+k, engine done 20 cycles after conv rises.
        check("ch2_k8", exp_kern(2) >> 64, 72'h28);
        run_layer(0, 20, 1'b0);

        // start with abort in IDLE is rejected.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("startabort_busy", 72'(busy), 72'(0));
        check("startabort_wen", 72'(w_en), 72'(0));
        tick();
        check("startabort_busy2", 72'(busy), 72'(0));

        run_layer(1, 20, 1'b0);
        run_layer(2, 10, 1'b0);
        run_layer(0, 3, 1'b0);

        // Random weights, random engine latencies and spurious start/conv_done.
        for (int i = 0; i < 64; i++) wmem[i] = 8'($urandom);
        for (int n = 0; n < 3; n++) run_layer(0, 0, 1'b1);

        // Single-channel layer with engine done already high at first RUN cycle.
        exp1 = {wmem1[8], wmem1[7], wmem1[6], wmem1[5], wmem1[4],
                wmem1[3], wmem1[2], wmem1[1], wmem1[0]};
        conv_done1 = 1'b1;
        start1     = 1'b1;
        tick();
        start1 = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            check("deg_conv", 72'(conv1), 72'(cyc == 11));
            check("deg_ldone", 72'(layer_done1), 72'(cyc == 12));
            check("deg_busy", 72'(busy1), 72'(cyc <= 12));
            if (cyc == 11) check("deg_kern", kcat1, exp1);
            tick();
        end
        conv_done1 = 1'b0;
        check("deg_ch", 72'(ch1), 72'(0));
        check("deg_kern_hold", kcat1, exp1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
